// File: rtl/cheshire_boot_seq_pkg.sv
// rtl/cheshire_boot_seq_pkg.sv - shared types and default constants for the boot sequencer
package cheshire_boot_seq_pkg;

  localparam logic [31:0] DefRstCycles     = 32'd16;
  localparam logic [31:0] DefStrapCycles   = 32'd4;
  localparam logic [31:0] DefTimeoutCycles = 32'd1000000;
  localparam int unsigned DefCntWidth      = 32'd32;

  // Boot mode that waits for the preload VIP before running
  localparam logic [1:0] BootModePassive = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_STRAP,
    ST_PRELOAD,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } boot_seq_state_e;

  // Raw EOC word as written by the SoC: bit0 flags a valid result
  typedef struct packed {
    logic [30:0] code;
    logic        valid;
  } eoc_code_t;

  function automatic logic is_busy(boot_seq_state_e s);
    return s inside {ST_RESET, ST_STRAP, ST_PRELOAD, ST_RUN};
  endfunction

endpackage

// File: rtl/cheshire_boot_seq_if.sv
// rtl/cheshire_boot_seq_if.sv - SoC-facing strap, reset, preload and EOC signals
interface cheshire_boot_seq_if;
  import cheshire_boot_seq_pkg::*;

  logic      soc_rst_no;
  logic      soc_test_mode_o;
  logic [1:0] soc_boot_mode_o;
  logic      preload_req_o;
  logic      preload_ack_i;
  logic      eoc_valid_i;
  eoc_code_t eoc_code_i;

  modport master (
    output soc_rst_no, soc_test_mode_o, soc_boot_mode_o, preload_req_o,
    input  preload_ack_i, eoc_valid_i, eoc_code_i
  );

  modport slave (
    input  soc_rst_no, soc_test_mode_o, soc_boot_mode_o, preload_req_o,
    output preload_ack_i, eoc_valid_i, eoc_code_i
  );

endinterface

// File: rtl/cheshire_boot_seq.sv
// rtl/cheshire_boot_seq.sv - boot phase sequencer: reset hold, straps, preload, run/EOC watch
module cheshire_boot_seq
  import cheshire_boot_seq_pkg::*;
#(
  parameter logic [31:0] RstCycles     = DefRstCycles,
  parameter logic [31:0] StrapCycles   = DefStrapCycles,
  parameter logic [31:0] TimeoutCycles = DefTimeoutCycles,
  parameter int unsigned CntWidth      = DefCntWidth
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [1:0]                  boot_mode_i,
  input  logic                        test_mode_i,
  input  logic                        abort_i,
  cheshire_boot_seq_if.master         soc,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        timeout_o,
  output logic [30:0]                 exit_code_o,
  output logic                        pass_o
);

  localparam logic [CntWidth-1:0] RstLoad     = CntWidth'(RstCycles - 32'd1);
  localparam logic [CntWidth-1:0] StrapLoad   = CntWidth'(StrapCycles - 32'd1);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 32'd1);
  localparam logic                TimeoutEn   = (TimeoutCycles != 32'd0);
  localparam logic [CntWidth-1:0] CntMax      = {CntWidth{1'b1}};

  boot_seq_state_e   state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [1:0]        boot_mode_q, boot_mode_d;
  logic              test_mode_q, test_mode_d;
  logic [30:0]       exit_code_q, exit_code_d;

  logic rst_no_q, preload_req_q, busy_q, done_q, timeout_q, pass_q;

  // State, shared counter, latched straps/result, and outputs decoded from the next state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      boot_mode_q   <= '0;
      test_mode_q   <= 1'b0;
      exit_code_q   <= '0;
      rst_no_q      <= 1'b0;
      preload_req_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      boot_mode_q   <= boot_mode_d;
      test_mode_q   <= test_mode_d;
      exit_code_q   <= exit_code_d;
      rst_no_q      <= state_d inside {ST_PRELOAD, ST_RUN, ST_DONE, ST_TIMEOUT};
      preload_req_q <= (state_d == ST_PRELOAD);
      busy_q        <= is_busy(state_d);
      done_q        <= (state_d == ST_DONE);
      timeout_q     <= (state_d == ST_TIMEOUT);
      pass_q        <= (state_d == ST_DONE) && (exit_code_d == '0);
    end
  end

  // Next-state logic; abort overrides any in-state decision while a boot is in flight
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    boot_mode_d = boot_mode_q;
    test_mode_d = test_mode_q;
    exit_code_d = exit_code_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start_i) begin
          boot_mode_d = boot_mode_i;
          test_mode_d = test_mode_i;
          exit_code_d = '0;
          cnt_d       = RstLoad;
          state_d     = ST_RESET;
        end
      end
      ST_RESET: begin
        if (cnt_q == '0) begin
          cnt_d   = StrapLoad;
          state_d = ST_STRAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STRAP: begin
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = (boot_mode_q == BootModePassive) ? ST_PRELOAD : ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PRELOAD: begin
        if (soc.preload_ack_i) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (soc.eoc_valid_i && soc.eoc_code_i.valid) begin
          exit_code_d = soc.eoc_code_i.code;
          state_d     = ST_DONE;
        end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
          state_d = ST_TIMEOUT;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i && is_busy(state_q)) begin
      state_d     = ST_RESET;
      cnt_d       = RstLoad;
      exit_code_d = exit_code_q;
    end
  end

  assign soc.soc_rst_no      = rst_no_q;
  assign soc.soc_test_mode_o = test_mode_q;
  assign soc.soc_boot_mode_o = boot_mode_q;
  assign soc.preload_req_o   = preload_req_q;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign exit_code_o = exit_code_q;
  assign pass_o      = pass_q;

endmodule

// File: tb/tb_cheshire_boot_seq.sv
// tb/tb_cheshire_boot_seq.sv - directed self-checking bench for cheshire_boot_seq
module tb_cheshire_boot_seq;
  import cheshire_boot_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  boot_mode = 2'b00;
  logic        test_mode = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, timeout, pass;
  logic [30:0] exit_code;

  int tests = 0;
  int fails = 0;
  int n;

  cheshire_boot_seq_if sif ();

  cheshire_boot_seq #(
    .RstCycles    (32'd16),
    .StrapCycles  (32'd4),
    .TimeoutCycles(32'd1000),
    .CntWidth     (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .boot_mode_i (boot_mode),
    .test_mode_i (test_mode),
    .abort_i     (abort),
    .soc         (sif.master),
    .busy_o      (busy),
    .done_o      (done),
    .timeout_o   (timeout),
    .exit_code_o (exit_code),
    .pass_o      (pass)
  );

  always #5 clk = ~clk;

  task automatic tick(input int cycles = 1);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles with the SoC held in reset, starting from the current one
  task automatic count_reset_low(output int cycles);
    cycles = 0;
    while (sif.soc_rst_no === 1'b0 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic pulse_start(input logic [1:0] bm, input logic tm);
    boot_mode = bm;
    test_mode = tm;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.preload_ack_i = 1'b0;
    sif.eoc_valid_i   = 1'b0;
    sif.eoc_code_i    = '0;

    tick(2);
    chk("rst_soc_rst_no", sif.soc_rst_no, 0);
    chk("rst_straps", {sif.soc_test_mode_o, sif.soc_boot_mode_o}, 0);
    chk("rst_req", sif.preload_req_o, 0);
    chk("rst_flags", {busy, done, timeout, pass}, 0);
    chk("rst_exit", exit_code, 0);
    rst = 1'b0;
    tick(2);

    // Autonomous boot
    pulse_start(2'b01, 1'b1);
    chk("auto_busy", busy, 1);
    chk("auto_straps", {sif.soc_test_mode_o, sif.soc_boot_mode_o}, 3'b101);
    count_reset_low(n);
    chk("auto_rst_low", n, 20);
    chk("auto_no_req", sif.preload_req_o, 0);
    tick(99);
    chk("auto_run_busy", {busy, done}, 2'b10);
    sif.eoc_valid_i = 1'b1;
    sif.eoc_code_i  = 32'h1;
    tick();
    sif.eoc_valid_i = 1'b0;
    chk("auto_done", {busy, done, timeout, pass}, 4'b0101);
    chk("auto_exit", exit_code, 0);
    sif.eoc_valid_i = 1'b1;
    sif.eoc_code_i  = 32'h5;
    tick();
    sif.eoc_valid_i = 1'b0;
    chk("done_eoc_ignored", {done, exit_code}, {1'b1, 31'd0});
    chk("done_rst_high", sif.soc_rst_no, 1);

    // Passive boot from DONE
    pulse_start(2'b00, 1'b0);
    chk("pass_restart_cleared", {busy, done, pass}, 3'b100);
    count_reset_low(n);
    chk("pass_rst_low", n, 20);
    chk("pass_req_rise", sif.preload_req_o, 1);
    tick(49);
    chk("pass_req_held", sif.preload_req_o, 1);
    sif.preload_ack_i = 1'b1;
    tick();
    sif.preload_ack_i = 1'b0;
    chk("pass_req_drop", {sif.preload_req_o, sif.soc_rst_no, busy}, 3'b011);

    // Ignored inputs while running
    sif.eoc_valid_i = 1'b1;
    sif.eoc_code_i  = 32'h6;
    tick();
    sif.eoc_valid_i = 1'b0;
    chk("ign_eoc_bit0", {busy, done}, 2'b10);
    sif.preload_ack_i = 1'b1;
    tick();
    sif.preload_ack_i = 1'b0;
    chk("ign_ack", {busy, sif.preload_req_o}, 2'b10);
    pulse_start(2'b11, 1'b1);
    chk("ign_start", {busy, sif.soc_rst_no, sif.soc_test_mode_o, sif.soc_boot_mode_o}, 5'b11000);
    sif.eoc_valid_i = 1'b1;
    sif.eoc_code_i  = 32'h7;
    tick();
    sif.eoc_valid_i = 1'b0;
    chk("pass_done", {done, pass}, 2'b10);
    chk("pass_exit", exit_code, 3);

    // Timeout with no EOC
    pulse_start(2'b01, 1'b0);
    chk("to_exit_cleared", exit_code, 0);
    count_reset_low(n);
    chk("to_rst_low", n, 20);
    tick(999);
    chk("to_not_yet", {busy, timeout}, 2'b10);
    tick();
    chk("to_fired", {busy, done, timeout, pass}, 4'b0010);

    // EOC coinciding with expiry
    pulse_start(2'b01, 1'b0);
    chk("to2_timeout_cleared", timeout, 0);
    count_reset_low(n);
    tick(999);
    sif.eoc_valid_i = 1'b1;
    sif.eoc_code_i  = 32'h1;
    tick();
    sif.eoc_valid_i = 1'b0;
    chk("to2_eoc_wins", {done, timeout, pass}, 3'b101);

    // Abort in RUN
    pulse_start(2'b10, 1'b1);
    count_reset_low(n);
    tick(30);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rst", {sif.soc_rst_no, busy}, 2'b01);
    chk("abort_straps", {sif.soc_test_mode_o, sif.soc_boot_mode_o}, 3'b110);
    count_reset_low(n);
    chk("abort_rst_low", n, 20);
    tick(5);
    sif.eoc_valid_i = 1'b1;
    sif.eoc_code_i  = 32'h3;
    tick();
    sif.eoc_valid_i = 1'b0;
    chk("abort_rerun_done", {done, pass, exit_code}, {2'b10, 31'd1});

    // Asynchronous reset during PRELOAD
    pulse_start(2'b00, 1'b1);
    count_reset_low(n);
    tick(5);
    chk("pre_req", sif.preload_req_o, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out", {sif.soc_rst_no, sif.preload_req_o, busy}, 3'b000);
    chk("async_rst_straps", {sif.soc_test_mode_o, sif.soc_boot_mode_o}, 3'b000);
    tick();
    rst = 1'b0;
    tick();

    // Abort ignored in IDLE; start beats abort
    abort = 1'b1;
    tick();
    chk("idle_abort_ign", busy, 0);
    start = 1'b1;
    boot_mode = 2'b01;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_beats_abort", {busy, sif.soc_rst_no, sif.soc_boot_mode_o}, 4'b1001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
